// File: rtl/conv_window_scheduler_if.sv
// Handshake and status bundle between the 5x5 convolution scheduler and its line-buffer/MAC neighbours.
// master drives frame start, column-valid and MAC-ready; slave is the scheduler.
interface conv_window_scheduler_if #(
  parameter int COL_W = 5,
  parameter int ROW_W = 5
);
  logic             start;
  logic             valid_line_win;
  logic             ready_win;
  logic             win_shift;
  logic             valid_win_MAC;
  logic             ready_MAC;
  logic [COL_W-1:0] out_col;
  logic [ROW_W-1:0] out_row;
  logic             busy;
  logic             line_done;
  logic             frame_done;
  logic [15:0]      stall_cycles;

  modport master (
    output start, valid_line_win, ready_MAC,
    input  ready_win, win_shift, valid_win_MAC, out_col, out_row,
           busy, line_done, frame_done, stall_cycles
  );

  modport slave (
    input  start, valid_line_win, ready_MAC,
    output ready_win, win_shift, valid_win_MAC, out_col, out_row,
           busy, line_done, frame_done, stall_cycles
  );
endinterface

// File: rtl/conv_window_scheduler.sv
// Frame sequencer for a KxK sliding window: fills K columns per output row, then alternates MAC window / column shift.
// Optional MAC backpressure counter enabled by defining CONV_SCHED_STALL_CNT_EN.
module conv_window_scheduler #(
  parameter int KERNEL_SIZE = 5,
  parameter int IMG_WIDTH   = 28,
  parameter int IMG_HEIGHT  = 28
) (
  input logic                    clk,
  input logic                    rst,
  conv_window_scheduler_if.slave bus
);
  localparam int CONV_PER_LINE = IMG_WIDTH - KERNEL_SIZE + 1;
  localparam int OUT_ROWS      = IMG_HEIGHT - KERNEL_SIZE + 1;
  localparam int COL_W = (CONV_PER_LINE > 1) ? $clog2(CONV_PER_LINE) : 1;
  localparam int ROW_W = (OUT_ROWS > 1) ? $clog2(OUT_ROWS) : 1;
  localparam int K_W   = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;

  localparam logic [K_W-1:0]   LAST_K   = K_W'(KERNEL_SIZE - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(CONV_PER_LINE - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(OUT_ROWS - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_FILL     = 3'd1;
  localparam logic [2:0] S_WIN      = 3'd2;
  localparam logic [2:0] S_SHIFT    = 3'd3;
  localparam logic [2:0] S_LINE_END = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [K_W-1:0]   col_cnt_q, col_cnt_d;
  logic [COL_W-1:0] out_col_q, out_col_d;
  logic [ROW_W-1:0] out_row_q, out_row_d;
  logic             ready_win;
  logic             shift;

  // Handshakes are pure decodes of the registered state, so nothing can change under a pending MAC window.
  assign ready_win = (state_q == S_FILL) || (state_q == S_SHIFT);
  assign shift     = ready_win && bus.valid_line_win;

  always_comb begin
    state_d   = state_q;
    col_cnt_d = col_cnt_q;
    out_col_d = out_col_q;
    out_row_d = out_row_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d   = S_FILL;
          col_cnt_d = '0;
          out_col_d = '0;
          out_row_d = '0;
        end
      end
      S_FILL: begin
        if (shift) begin
          if (col_cnt_q == LAST_K) begin
            col_cnt_d = '0;
            out_col_d = '0;
            state_d   = S_WIN;
          end else begin
            col_cnt_d = col_cnt_q + K_W'(1);
          end
        end
      end
      S_WIN: begin
        if (bus.ready_MAC) begin
          state_d = (out_col_q == LAST_COL) ? S_LINE_END : S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (shift) begin
          out_col_d = out_col_q + COL_W'(1);
          state_d   = S_WIN;
        end
      end
      S_LINE_END: begin
        if (out_row_q == LAST_ROW) begin
          state_d = S_DONE;
        end else begin
          out_row_d = out_row_q + ROW_W'(1);
          state_d   = S_FILL;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      col_cnt_q <= '0;
      out_col_q <= '0;
      out_row_q <= '0;
    end else begin
      state_q   <= state_d;
      col_cnt_q <= col_cnt_d;
      out_col_q <= out_col_d;
      out_row_q <= out_row_d;
    end
  end

  assign bus.ready_win     = ready_win;
  assign bus.win_shift     = shift;
  assign bus.valid_win_MAC = (state_q == S_WIN);
  assign bus.out_col       = out_col_q;
  assign bus.out_row       = out_row_q;
  assign bus.busy          = (state_q != S_IDLE);
  assign bus.line_done     = (state_q == S_LINE_END);
  assign bus.frame_done    = (state_q == S_DONE);

`ifdef CONV_SCHED_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  // Counts cycles a complete window waits on the MAC; saturates and survives past frame_done.
  always_comb begin
    stall_d = stall_q;
    if ((state_q == S_IDLE) && bus.start) begin
      stall_d = '0;
    end else if ((state_q == S_WIN) && !bus.ready_MAC && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  assign bus.stall_cycles = stall_q;
`else
  assign bus.stall_cycles = '0;
`endif
endmodule
